// File: rtl/puertos_salida_if.sv
// Write bus driven by the processor output stage (salidas) into the port bank.
interface puertos_salida_if;
  logic       LE;
  logic [7:0] DataOut_Bus;
  logic [7:0] Addres_Data_Bus;
  logic       ErrClr;

  modport master (output LE, DataOut_Bus, Addres_Data_Bus, ErrClr);
  modport slave  (input  LE, DataOut_Bus, Addres_Data_Bus, ErrClr);
endinterface

// File: rtl/puertos_salida.sv
// Output-port bank: latches data into NUM_PORTS 8-bit registers on each rising LE.
// Optional combinational readback port enabled by defining PUERTOS_READBACK_EN.
module puertos_salida #(
  parameter int unsigned NUM_PORTS = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                   Clk,
  input  logic                   Rst,
  puertos_salida_if.slave        bus,
  output logic [8*NUM_PORTS-1:0] Ports,
  output logic [NUM_PORTS-1:0]   Upd,
  output logic [7:0]             WrCnt,
  output logic                   Err
`ifdef PUERTOS_READBACK_EN
  ,
  output logic [7:0]             RdData
`endif
);

  localparam logic [7:0] NUM_PORTS_B = 8'(NUM_PORTS);

  logic       le_d;
  logic       wr_ev;
  logic [7:0] idx;
  logic       in_range;

  // Address below BASE_ADDR wraps to a large idx and falls out of range.
  always_comb begin
    wr_ev    = bus.LE & ~le_d;
    idx      = bus.Addres_Data_Bus - BASE_ADDR;
    in_range = (idx < NUM_PORTS_B);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      le_d  <= 1'b1;
      Ports <= {NUM_PORTS{RESET_VAL}};
      Upd   <= '0;
      WrCnt <= 8'h00;
      Err   <= 1'b0;
    end else begin
      le_d <= bus.LE;
      Upd  <= '0;
      if (bus.ErrClr) Err <= 1'b0;
      if (wr_ev) begin
        if (in_range) begin
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (idx == 8'(i)) begin
              Ports[8*i +: 8] <= bus.DataOut_Bus;
              Upd[i]          <= 1'b1;
            end
          end
          WrCnt <= WrCnt + 8'd1;
        end else begin
          // Set takes priority over a simultaneous ErrClr.
          Err <= 1'b1;
        end
      end
    end
  end

`ifdef PUERTOS_READBACK_EN
  always_comb begin
    RdData = 8'h00;
    if (in_range) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (idx == 8'(i)) RdData = Ports[8*i +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_puertos_salida.sv
// Directed bench for puertos_salida (default 4 ports at 8'hF0, reset value 8'h00).
module tb_puertos_salida;

  logic        clk;
  logic        rst;
  logic [31:0] ports;
  logic [3:0]  upd;
  logic [7:0]  wr_cnt;
  logic        err;
`ifdef PUERTOS_READBACK_EN
  logic [7:0]  rd_data;
`endif

  int vectors;
  int errors;

  puertos_salida_if bus ();

  puertos_salida #(
    .NUM_PORTS(4),
    .BASE_ADDR(8'hF0),
    .RESET_VAL(8'h00)
  ) dut (
    .Clk   (clk),
    .Rst   (rst),
    .bus   (bus),
    .Ports (ports),
    .Upd   (upd),
    .WrCnt (wr_cnt),
    .Err   (err)
`ifdef PUERTOS_READBACK_EN
    ,
    .RdData(rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic [7:0] addr, input logic [7:0] data);
    bus.LE              = le;
    bus.Addres_Data_Bus = addr;
    bus.DataOut_Bus     = data;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ErrClr = 1'b0;
    drive(1'b1, 8'hF2, 8'hAA);
    repeat (3) tick();
    vectors++;
    if (ports !== 32'h0 || upd !== 4'h0 || wr_cnt !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ports=%h upd=%b cnt=%h err=%b, want 0/0/0/0", ports, upd, wr_cnt, err);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (ports !== 32'h0 || upd !== 4'h0 || wr_cnt !== 8'h00) begin
        errors++;
        $display("FAIL reset_le_held[%0d]: ports=%h upd=%b cnt=%h, want no write", k, ports, upd, wr_cnt);
      end
    end
  endtask

  task automatic test_single_write();
    drive(1'b0, 8'hF2, 8'h00);
    tick();
    drive(1'b1, 8'hF2, 8'h5A);
    tick();
    vectors++;
    if (ports !== 32'h005A_0000 || upd !== 4'b0100 || wr_cnt !== 8'd1) begin
      errors++;
      $display("FAIL single_write: ports=%h upd=%b cnt=%h, want 005a0000/0100/01", ports, upd, wr_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'hF1, 8'hFF);
      tick();
      vectors++;
      if (ports !== 32'h005A_0000 || upd !== 4'b0000 || wr_cnt !== 8'd1) begin
        errors++;
        $display("FAIL single_hold[%0d]: ports=%h upd=%b cnt=%h, want 005a0000/0000/01", k, ports, upd, wr_cnt);
      end
    end
    drive(1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'hF3, 8'h99);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (ports !== 32'h0 || upd !== 4'h0 || wr_cnt !== 8'h00 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ports=%h upd=%b cnt=%h err=%b, want all zero", ports, upd, wr_cnt, err);
    end
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (ports !== 32'h0 || upd !== 4'h0 || wr_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_le_high: ports=%h upd=%b cnt=%h, want no write", ports, upd, wr_cnt);
    end
    drive(1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'hF0, 8'h11);
    tick();
    vectors++;
    if (upd !== 4'b0001 || wr_cnt !== 8'd1 || ports !== 32'h0000_0011) begin
      errors++;
      $display("FAIL b2b_w0: ports=%h upd=%b cnt=%h, want 00000011/0001/01", ports, upd, wr_cnt);
    end
    drive(1'b0, 8'hF0, 8'h11);
    tick();
    vectors++;
    if (upd !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_gap0: upd=%b, want 0000", upd);
    end
    drive(1'b1, 8'hF3, 8'h22);
    tick();
    vectors++;
    if (upd !== 4'b1000 || wr_cnt !== 8'd2) begin
      errors++;
      $display("FAIL b2b_w1: upd=%b cnt=%h, want 1000/02", upd, wr_cnt);
    end
    drive(1'b0, 8'hF3, 8'h22);
    tick();
    vectors++;
    if (upd !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_gap1: upd=%b, want 0000", upd);
    end
    drive(1'b1, 8'hF1, 8'h33);
    tick();
    vectors++;
    if (upd !== 4'b0010 || wr_cnt !== 8'd3 || ports !== 32'h2200_3311) begin
      errors++;
      $display("FAIL b2b_w2: ports=%h upd=%b cnt=%h, want 22003311/0010/03", ports, upd, wr_cnt);
    end
    drive(1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_out_of_range();
    logic [7:0] bad [2];
    bad[0] = 8'h05;
    bad[1] = 8'hF4;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, bad[k], 8'h77);
      tick();
      vectors++;
      if (ports !== 32'h2200_3311 || wr_cnt !== 8'd3 || upd !== 4'h0 || err !== 1'b1) begin
        errors++;
        $display("FAIL oor_%h: ports=%h upd=%b cnt=%h err=%b, want 22003311/0000/03/1",
                 bad[k], ports, upd, wr_cnt, err);
      end
      drive(1'b0, 8'h00, 8'h00);
      tick();
    end
    vectors++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    bus.ErrClr = 1'b1;
    drive(1'b1, 8'hEF, 8'h44);
    tick();
    vectors++;
    if (err !== 1'b1 || wr_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_set_wins: err=%b cnt=%h, want 1/03", err, wr_cnt);
    end
    bus.ErrClr = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    tick();
    bus.ErrClr = 1'b1;
    tick();
    bus.ErrClr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
  endtask

  task automatic test_counter_wrap();
    for (int n = 0; n < 256; n++) begin
      drive(1'b1, 8'hF0 + 8'(n % 4), 8'(n));
      tick();
      if (n == 254) begin
        vectors++;
        if (wr_cnt !== 8'hFF) begin
          errors++;
          $display("FAIL wrap_ff: cnt=%h, want ff", wr_cnt);
        end
      end
      drive(1'b0, 8'h00, 8'h00);
      tick();
    end
    vectors++;
    if (wr_cnt !== 8'h00 || ports !== 32'hFFFE_FDFC) begin
      errors++;
      $display("FAIL wrap_00: cnt=%h ports=%h, want 00/fffefdfc", wr_cnt, ports);
    end
  endtask

  task automatic test_same_value();
    drive(1'b1, 8'hF2, 8'hFE);
    tick();
    vectors++;
    if (upd !== 4'b0100 || wr_cnt !== 8'h01 || ports !== 32'hFFFE_FDFC) begin
      errors++;
      $display("FAIL same_value: upd=%b cnt=%h ports=%h, want 0100/01/fffefdfc", upd, wr_cnt, ports);
    end
    drive(1'b0, 8'h00, 8'h00);
    tick();
  endtask

`ifdef PUERTOS_READBACK_EN
  task automatic test_readback();
    drive(1'b1, 8'hF1, 8'hC3);
    tick();
    drive(1'b0, 8'hF1, 8'h00);
    #1;
    vectors++;
    if (rd_data !== 8'hC3) begin
      errors++;
      $display("FAIL readback_f1: rd=%h, want c3", rd_data);
    end
    bus.Addres_Data_Bus = 8'h10;
    #1;
    vectors++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL readback_10: rd=%h, want 00", rd_data);
    end
    tick();
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_single_write();
    test_reset_mid();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_counter_wrap();
    test_same_value();
`ifdef PUERTOS_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/puertos_salida.md
# puertos_salida

Output-port bank sitting directly downstream of the processor output stage (`salidas`). It watches the latch-enable, data and address buses that stage drives, and detects each rising edge of `LE`. On that edge it decodes the address and latches the data byte into one of `NUM_PORTS` 8-bit output registers, which drive board-level pins. It also emits per-port update strobes, keeps a wrapping count of accepted writes, and flags writes to unmapped addresses in a sticky error bit.

## Interface
- `NUM_PORTS`, 4: number of 8-bit output ports (1–8).
- `BASE_ADDR`, 8'hF0: address of port 0; port i lives at `BASE_ADDR + i`.
- `RESET_VAL`, 8'h00: reset value of every port register.

- `Clk`  in  1  system clock; all state changes on rising edge.
- `Rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `LE`  in  1  latch enable from output stage; a write is its 0→1 transition.
- `DataOut_Bus`  in  8  write data.
- `Addres_Data_Bus`  in  8  write address.
- `ErrClr`  in  1  synchronous clear of `Err`.
- `Ports`  out  8*NUM_PORTS  port registers; port i = bits [8i+7:8i].
- `Upd`  out  NUM_PORTS  one-cycle strobe, bit i high in the cycle after port i was written.
- `WrCnt`  out  8  number of accepted (in-range) writes, modulo 256.
- `Err`  out  1  sticky out-of-range-write flag.

## Operation
- Edge detect:
  - `le_d` is a register holding `LE` from the previous cycle.
  - A write event occurs at a rising `Clk` where `LE`=1 and `le_d`=0.
  - `le_d` resets to 1, so `LE` held high through reset release does not write.
- Holding `LE` high for N cycles produces exactly one write event. `LE` must return to 0 for at least one sampled cycle before the next write.
- On a write event, compute `idx = Addres_Data_Bus - BASE_ADDR` as an 8-bit unsigned value.
- In range (`idx < NUM_PORTS`):
  - `Ports[idx]` is loaded with `DataOut_Bus`.
  - `Upd[idx]` is set to 1.
  - `WrCnt` increments and wraps 8'hFF→8'h00.
- Out of range, including addresses below `BASE_ADDR`, which wrap to a large `idx`:
  - No port changes.
  - `WrCnt` is unchanged.
  - `Err` is set to 1.
- `Upd` is zero in every cycle with no in-range write event. At most one bit is high at a time.
- `Err` clears only on `ErrClr`=1 at a clock edge. If `ErrClr` and an out-of-range write event fall on the same edge, `Err` ends at 1 (set wins).
- Writing the same value a port already holds is still a write: it strobes `Upd` and counts.

## Timing
- Reset values, applied asynchronously while `Rst`=0:
  - every port = `RESET_VAL`
  - `Upd` = 0
  - `WrCnt` = 0
  - `Err` = 0
  - `le_d` = 1
- Latency:
  - Data and address are sampled at the edge where `LE` is first seen high.
  - `Ports`, `Upd`, `WrCnt` and `Err` all reflect that write immediately after the same edge, i.e. 1 clock after `LE` is presented.
- Back-to-back writes: the minimum spacing is 2 clocks (`LE` high, then low), giving one write every 2 cycles at most.
- Reset mid-operation:
  - Asserting `Rst` forces all outputs to reset values regardless of `LE`.
  - After deassertion, `LE` must be seen low once before any write is accepted.
- Data and address are don't-care except at the write-event edge.

## Configuration
- `PUERTOS_READBACK_EN` defined:
  - Adds output `RdData` [7:0], driven combinationally.
  - `RdData` is `Ports[idx]` decoded from the current `Addres_Data_Bus` when in range, else 8'h00.
  - It is independent of `LE`, so the processor can read ports back.
- Undefined: `RdData` port and decode logic are absent; all other behaviour is identical.

## Test plan
- Reset and hold:
  - Stimulus: `Rst`=0 for 3 clocks with `LE`=1, then `Rst`=1 with `LE` still 1 for 3 clocks.
  - Required: all `Ports`=8'h00, `WrCnt`=0, `Upd`=0, `Err`=0, and no write.
- Single write:
  - Stimulus: addr 8'hF2, data 8'h5A, `LE` 0→1 held 4 cycles.
  - Required: after one edge, port 2 = 8'h5A, `Upd`=4'b0100 for exactly 1 cycle, `WrCnt`=1, other ports 8'h00.
- Back-to-back writes:
  - Stimulus: writes F0←8'h11, F3←8'h22, F1←8'h33 with the `LE` pattern 1,0,1,0,1.
  - Required: `Ports`={22,00,33,11} (port 3..0), `WrCnt`=3, three single-cycle `Upd` pulses.
- Out-of-range addresses:
  - Stimulus: write to addr 8'h05, then to 8'hF4.
  - Required: ports unchanged, `WrCnt` unchanged, `Err`=1.
  - Then `ErrClr` on the same edge as an out-of-range write: `Err` stays 1.
  - Then `ErrClr` alone: `Err`=0.
- Counter wrap:
  - Stimulus: 256 in-range writes.
  - Required: `WrCnt` returns to 8'h00, with correct values at 255.
- Readback (with `PUERTOS_READBACK_EN`):
  - Stimulus: after port 1 = 8'hC3, set addr 8'hF1, then addr 8'h10.
  - Required: `RdData`=8'hC3 for addr 8'hF1, and 8'h00 for addr 8'h10.
